multi_clock_divider: RTL and testbench
======================================

Name: multi_clock_divider

Overview:
- Parametrised successor to the single fixed-ratio interconnect clock divider.
- Generates NUM_CH independent divided clocks from one core clock, clk_in. Each channel has a runtime-programmable ratio, glitch-free enable and ratio change, and core-domain strobes marking divided-clock edges.
- Sits between the core clock and the interconnect, router and memory clock domains of the simulator top level.

Parameters:
- NUM_CH, 2: number of independent divided-clock channels.
- RATIO_W, 8: width of the ratio field; legal ratio range is 2..2^RATIO_W-1.
- DEFAULT_RATIO, 2: ratio of every channel after reset. Must satisfy 2 <= DEFAULT_RATIO < 2^RATIO_W, otherwise elaboration fails.
- CNT_W, 32: width of each per-channel rising-edge counter.

Ports:
- clk_in  input  1: core clock; all logic is posedge clk_in unless stated otherwise.
- rst_l  input  1: asynchronous, active-low reset.
- ch_en  input  NUM_CH: per-channel run request, level sensitive.
- ratio_load  input  NUM_CH: one-cycle request to load ratio_in for that channel.
- ratio_in  input  NUM_CH x RATIO_W: requested ratio per channel.
- clk_out  output  NUM_CH: divided clocks, registered.
- rise_strobe  output  NUM_CH: one-clk_in-cycle pulse, high in the cycle clk_out rises.
- fall_strobe  output  NUM_CH: one-clk_in-cycle pulse, high in the cycle clk_out falls.
- load_ack  output  NUM_CH: one-cycle pulse when a pending ratio becomes active.
- load_err  output  NUM_CH: one-cycle pulse, asserted the cycle after an illegal ratio_load.
- ratio_active  output  NUM_CH x RATIO_W: ratio currently in effect.
- edge_count  output  NUM_CH x CNT_W: number of clk_out rising edges since reset.

Behaviour:
- Reset (asynchronous on rst_l low) sets every channel as follows:
  - state IDLE, count 0, clk_out 0, all strobes, load_ack and load_err 0.
  - ratio_active = DEFAULT_RATIO, no pending ratio, edge_count 0.
- Per-channel FSM:
  - IDLE -> RUN when ch_en is sampled 1.
  - RUN -> STOPPING when ch_en is sampled 0.
  - STOPPING -> IDLE at the period wrap, i.e. the edge where count would return to 0.
  - STOPPING -> RUN if ch_en returns to 1 before the wrap; the current period is not disturbed.
- Counting: let R = ratio_active and H = R>>1.
  - In RUN and STOPPING, count steps 0..R-1 and wraps to 0.
  - clk_out == (count < H) in every cycle; even R gives 50% duty, odd R gives H high and R-H low.
- First period after IDLE -> RUN: the cycle after ch_en is sampled high has count=0, clk_out=1 and rise_strobe=1.
- In IDLE, clk_out is held 0 and count is held 0. No runt pulses are allowed on enable or disable.
- Strobes:
  - rise_strobe is high exactly in cycles with count==0 while running.
  - fall_strobe is high exactly in cycles with count==H.
  - edge_count increments by 1 on every rise_strobe and wraps modulo 2^CNT_W.
- Ratio load:
  - A legal ratio_in (>= 2) with ratio_load=1 is captured into that channel's pending register.
  - A second load before the pending ratio is applied overwrites it; only the last one is applied and only one load_ack is issued.
  - The pending ratio is applied at the next period wrap, so the new period starts at count 0 with the new R.
  - load_ack pulses in the first cycle of the new period, coincident with rise_strobe.
  - In IDLE, the pending ratio is applied on the next edge and load_ack pulses then.
  - ratio_in of 0 or 1 is ignored: load_err pulses and pending/active are unchanged.
- Simultaneous events:
  - Load and wrap on the same edge: the previously pending value is applied; the new value becomes pending.
  - Disable and wrap on the same edge: go to IDLE.
- Channels are fully independent; no cross-channel phase relation is guaranteed.
- Reset mid-period: clk_out drops to 0 asynchronously, and the pending ratio is discarded.

Optional Feature:
- Macro: DIV_ODD_DUTY50_EN.
- Defined: for odd R, a negedge-clk_in flop extends the high phase by half a clk_in cycle, so clk_out is high for R/2 clk_in periods (exact 50% duty).
  - clk_out becomes the OR of the posedge term and the negedge-retimed term.
  - Strobes and counters are unchanged, still posedge-only.
- Not defined: purely posedge logic; odd R gives the H/(R-H) duty described above. Even R is identical in both builds.

Test Plan:
- Reset, then ch_en[0]=1 with DEFAULT_RATIO=2 -> clk_out[0] toggles every clk_in cycle starting high; edge_count[0]=10 after 20 cycles.
- Load ratio 6 mid-period while running at R=4 -> old period completes; the next period has clk_out high 3 and low 3 cycles; load_ack is coincident with rise_strobe.
- Load 5, then load 8 before the wrap -> only R=8 is applied; one load_ack; ratio_active=8.
- Load ratio 1, then ratio 0 -> load_err pulses twice; ratio_active is unchanged.
- Drop ch_en at count=1 with R=8 -> clk_out completes the full period (4 high, 4 low) and then stays 0; re-enable gives a full high phase of 4 cycles.
- Assert rst_l=0 mid-high-phase with R=6 on channel 1 while channel 0 runs R=3 -> both clk_out go 0 immediately; after release ratio_active = DEFAULT_RATIO and edge_count=0.

Source files
------------

// File: rtl/multi_clock_divider.sv
// -----------------------------------------------------------------------------
// multi_clock_divider
//
// Generates NUM_CH independent divided clocks from the core clock clk_in.
// Every channel has a runtime-programmable ratio, a glitch-free enable and
// ratio change, and core-domain strobes that mark its divided-clock edges.
// It replaces the old single fixed-ratio interconnect divider. It feeds the
// interconnect, router and memory clock domains of the simulator top level.
//
// Optional build macro: DIV_ODD_DUTY50_EN
//   Defined   : for odd ratios, a negedge flop stretches the high phase by
//               half a clk_in period, which gives an exact 50% duty. Strobes
//               and counters stay posedge-only.
//   Undefined : the design is purely posedge. An odd R gives H high cycles
//               and R-H low cycles. Even R behaves the same in both builds.
//
// Parameters
//   NUM_CH        number of divided-clock channels
//   RATIO_W       width of a ratio field (legal ratio 2 .. 2^RATIO_W-1)
//   DEFAULT_RATIO ratio of every channel after reset
//   CNT_W         width of each rising-edge counter
//
// Ports
//   clk_in        core clock
//   rst_l         asynchronous active-low reset
//   ch_en         per-channel run request (level)
//   ratio_load    per-channel one-cycle load request for ratio_in
//   ratio_in      requested ratio, RATIO_W bits per channel
//   clk_out       divided clocks
//   rise_strobe   high in the clk_in cycle in which clk_out rises
//   fall_strobe   high in the clk_in cycle in which clk_out falls
//   load_ack      pulse when a pending ratio becomes active
//   load_err      pulse the cycle after a ratio_load of 0 or 1
//   ratio_active  ratio currently in effect, RATIO_W bits per channel
//   edge_count    clk_out rising edges since reset, CNT_W bits per channel
// -----------------------------------------------------------------------------
module multi_clock_divider #(
    parameter int NUM_CH        = 2,
    parameter int RATIO_W       = 8,
    parameter int DEFAULT_RATIO = 2,
    parameter int CNT_W         = 32
) (
    input  logic                        clk_in,
    input  logic                        rst_l,
    input  logic [NUM_CH-1:0]           ch_en,
    input  logic [NUM_CH-1:0]           ratio_load,
    input  logic [NUM_CH*RATIO_W-1:0]   ratio_in,
    output logic [NUM_CH-1:0]           clk_out,
    output logic [NUM_CH-1:0]           rise_strobe,
    output logic [NUM_CH-1:0]           fall_strobe,
    output logic [NUM_CH-1:0]           load_ack,
    output logic [NUM_CH-1:0]           load_err,
    output logic [NUM_CH*RATIO_W-1:0]   ratio_active,
    output logic [NUM_CH*CNT_W-1:0]     edge_count
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_e;

    localparam logic [RATIO_W-1:0] DEF_R     = RATIO_W'(DEFAULT_RATIO);
    localparam logic [RATIO_W-1:0] R_ONE     = {{(RATIO_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // An out-of-range default ratio would produce a stuck or runt clock.
    // Elaboration is stopped in that case.
    generate
        if ((DEFAULT_RATIO < 2) || (64'(DEFAULT_RATIO) >= (64'd1 << RATIO_W))) begin : g_bad_default
            $error("multi_clock_divider: DEFAULT_RATIO must satisfy 2 <= DEFAULT_RATIO < 2**RATIO_W");
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi = gi + 1) begin : g_ch
            state_e             state_q,    state_d;
            logic [RATIO_W-1:0] count_q,    count_d;
            logic [RATIO_W-1:0] ratio_q,    ratio_d;
            logic [RATIO_W-1:0] pend_q,     pend_d;
            logic               pend_vld_q, pend_vld_d;
            logic               clk_q,      clk_d;
            logic               rise_q,     rise_d;
            logic               fall_q,     fall_d;
            logic               ack_q,      ack_d;
            logic               err_q,      err_d;
            logic [CNT_W-1:0]   edges_q,    edges_d;

            logic [RATIO_W-1:0] ratio_req;
            logic [RATIO_W-1:0] half_d;
            logic               ratio_legal;
            logic               load_ok;
            logic               wrap;
            logic               apply;
            logic               run_d;

            assign ratio_req   = ratio_in[gi*RATIO_W +: RATIO_W];
            // A ratio is legal when it is >= 2, which means some bit above the LSB is set.
            assign ratio_legal = |ratio_req[RATIO_W-1:1];
            assign load_ok     = ratio_load[gi] & ratio_legal;
            // Last count of the current period. It only has meaning outside IDLE.
            assign wrap        = (count_q == (ratio_q - R_ONE));

            always_comb begin
                state_d    = state_q;
                count_d    = count_q;
                ratio_d    = ratio_q;
                pend_d     = pend_q;
                pend_vld_d = pend_vld_q;
                ack_d      = 1'b0;
                err_d      = ratio_load[gi] & ~ratio_legal;
                apply      = 1'b0;

                case (state_q)
                    ST_IDLE: begin
                        // While idle there is no period to protect. A pending
                        // ratio is taken on the next edge, and the first period
                        // after enable already uses it.
                        count_d = '0;
                        apply   = pend_vld_q;
                        if (ch_en[gi]) begin
                            state_d = ST_RUN;
                        end
                    end
                    ST_RUN, ST_STOPPING: begin
                        if (wrap) begin
                            count_d = '0;
                            apply   = pend_vld_q;
                            // A disable that is still present at the wrap ends the clock.
                            // Otherwise a new full period starts.
                            state_d = ch_en[gi] ? ST_RUN : ST_IDLE;
                        end else begin
                            count_d = count_q + R_ONE;
                            state_d = ch_en[gi] ? ST_RUN : ST_STOPPING;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        count_d = '0;
                    end
                endcase

                if (apply) begin
                    ratio_d    = pend_q;
                    pend_vld_d = 1'b0;
                    ack_d      = 1'b1;
                end

                // This test comes after apply. A load that lands on the apply
                // edge therefore becomes the next pending value and does not
                // replace the one just applied.
                if (load_ok) begin
                    pend_d     = ratio_req;
                    pend_vld_d = 1'b1;
                end

                // All outputs are registered versions of the next-state
                // relations, so clk_out, the strobes and count stay aligned.
                half_d  = ratio_d >> 1;
                run_d   = (state_d != ST_IDLE);
                clk_d   = run_d && (count_d < half_d);
                rise_d  = run_d && (count_d == '0);
                fall_d  = run_d && (count_d == half_d);
                edges_d = rise_d ? (edges_q + CNT_ONE) : edges_q;
            end

            always_ff @(posedge clk_in or negedge rst_l) begin
                if (!rst_l) begin
                    state_q    <= ST_IDLE;
                    count_q    <= '0;
                    ratio_q    <= DEF_R;
                    pend_q     <= DEF_R;
                    pend_vld_q <= 1'b0;
                    clk_q      <= 1'b0;
                    rise_q     <= 1'b0;
                    fall_q     <= 1'b0;
                    ack_q      <= 1'b0;
                    err_q      <= 1'b0;
                    edges_q    <= '0;
                end else begin
                    state_q    <= state_d;
                    count_q    <= count_d;
                    ratio_q    <= ratio_d;
                    pend_q     <= pend_d;
                    pend_vld_q <= pend_vld_d;
                    clk_q      <= clk_d;
                    rise_q     <= rise_d;
                    fall_q     <= fall_d;
                    ack_q      <= ack_d;
                    err_q      <= err_d;
                    edges_q    <= edges_d;
                end
            end

`ifdef DIV_ODD_DUTY50_EN
            // The negedge copy of the high phase holds clk_out high for half a
            // clk_in cycle after the posedge term falls. This happens only for
            // odd ratios and gives an exact 50% duty. The ratio can only change
            // at a wrap, when the posedge term has already been low for at least
            // one cycle, so the odd qualifier never cuts a phase short.
            logic ext_q, ext_d;

            always_comb begin
                ext_d = clk_q & ratio_q[0];
            end

            always_ff @(negedge clk_in or negedge rst_l) begin
                if (!rst_l) begin
                    ext_q <= 1'b0;
                end else begin
                    ext_q <= ext_d;
                end
            end

            assign clk_out[gi] = clk_q | ext_q;
`else
            assign clk_out[gi] = clk_q;
`endif

            assign rise_strobe[gi]                     = rise_q;
            assign fall_strobe[gi]                     = fall_q;
            assign load_ack[gi]                        = ack_q;
            assign load_err[gi]                        = err_q;
            assign ratio_active[gi*RATIO_W +: RATIO_W] = ratio_q;
            assign edge_count[gi*CNT_W +: CNT_W]       = edges_q;
        end
    endgenerate

endmodule

// File: tb/tb_multi_clock_divider.sv
// -----------------------------------------------------------------------------
// tb_multi_clock_divider
//
// Directed bench for multi_clock_divider with the default parameters
// (2 channels, 8-bit ratio, default ratio 2, 32-bit edge counters).
// Channel 0 runs from a vector table. Each record holds the inputs applied
// before a clk_in edge and the outputs expected just after that edge. A
// hand-written sequence then covers a reset in the middle of a period,
// using both channels.
// -----------------------------------------------------------------------------
module tb_multi_clock_divider;

    logic        clk_in;
    logic        rst_l;
    logic [1:0]  ch_en;
    logic [1:0]  ratio_load;
    logic [15:0] ratio_in;
    logic [1:0]  clk_out;
    logic [1:0]  rise_strobe;
    logic [1:0]  fall_strobe;
    logic [1:0]  load_ack;
    logic [1:0]  load_err;
    logic [15:0] ratio_active;
    logic [63:0] edge_count;

    int tests;
    int fails;

    typedef struct {
        logic       en;
        logic       ld;
        logic [7:0] rin;
        logic       clk;
        logic       rise;
        logic       fall;
        logic       ack;
        logic       err;
        logic [7:0] ratio;
        int         edges;
    } vec_t;

    vec_t vq[$];

    multi_clock_divider #(
        .NUM_CH        (2),
        .RATIO_W       (8),
        .DEFAULT_RATIO (2),
        .CNT_W         (32)
    ) dut (
        .clk_in       (clk_in),
        .rst_l        (rst_l),
        .ch_en        (ch_en),
        .ratio_load   (ratio_load),
        .ratio_in     (ratio_in),
        .clk_out      (clk_out),
        .rise_strobe  (rise_strobe),
        .fall_strobe  (fall_strobe),
        .load_ack     (load_ack),
        .load_err     (load_err),
        .ratio_active (ratio_active),
        .edge_count   (edge_count)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic ld, input logic [7:0] rin,
                       input logic clk, input logic rise, input logic fall,
                       input logic ack, input logic err, input logic [7:0] ratio,
                       input int edges);
        vec_t v;
        v.en = en; v.ld = ld; v.rin = rin;
        v.clk = clk; v.rise = rise; v.fall = fall;
        v.ack = ack; v.err = err; v.ratio = ratio; v.edges = edges;
        vq.push_back(v);
    endtask

    // Outputs are sampled 1 ns after the active edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        rst_l      = 1'b0;
        ch_en      = 2'b00;
        ratio_load = 2'b00;
        ratio_in   = 16'd0;

        // ---------------- vector table (channel 0) ----------------
        //   en ld rin  clk rise fall ack err ratio edges
        // Rows 1-20: R=2 toggles every cycle and starts high.
        for (int i = 1; i <= 20; i++) begin
            add(1'b1, 1'b0, 8'd0, 1'(i % 2), 1'(i % 2), 1'((i + 1) % 2), 1'b0, 1'b0, 8'd2, (i + 1) / 2);
        end
        // Load R=4 on the wrap edge. Stay on R=2 for one more period, then switch.
        add(1, 1, 8'd4, 1, 1, 0, 0, 0, 8'd2, 11);
        add(1, 0, 8'd0, 0, 0, 1, 0, 0, 8'd2, 11);
        add(1, 0, 8'd0, 1, 1, 0, 1, 0, 8'd4, 12);
        add(1, 0, 8'd0, 1, 0, 0, 0, 0, 8'd4, 12);
        // Load R=6 mid-period. The R=4 period completes first.
        add(1, 1, 8'd6, 0, 0, 1, 0, 0, 8'd4, 12);
        add(1, 0, 8'd0, 0, 0, 0, 0, 0, 8'd4, 12);
        add(1, 0, 8'd0, 1, 1, 0, 1, 0, 8'd6, 13);
        add(1, 0, 8'd0, 1, 0, 0, 0, 0, 8'd6, 13);
        add(1, 0, 8'd0, 1, 0, 0, 0, 0, 8'd6, 13);
        add(1, 0, 8'd0, 0, 0, 1, 0, 0, 8'd6, 13);
        add(1, 0, 8'd0, 0, 0, 0, 0, 0, 8'd6, 13);
        add(1, 0, 8'd0, 0, 0, 0, 0, 0, 8'd6, 13);
        add(1, 0, 8'd0, 1, 1, 0, 0, 0, 8'd6, 14);
        // Load 5, then 8 before the wrap. Only 8 is applied, with a single ack.
        add(1, 1, 8'd5, 1, 0, 0, 0, 0, 8'd6, 14);
        add(1, 1, 8'd8, 1, 0, 0, 0, 0, 8'd6, 14);
        add(1, 0, 8'd0, 0, 0, 1, 0, 0, 8'd6, 14);
        add(1, 0, 8'd0, 0, 0, 0, 0, 0, 8'd6, 14);
        add(1, 0, 8'd0, 0, 0, 0, 0, 0, 8'd6, 14);
        add(1, 0, 8'd0, 1, 1, 0, 1, 0, 8'd8, 15);
        add(1, 0, 8'd0, 1, 0, 0, 0, 0, 8'd8, 15);
        add(1, 0, 8'd0, 1, 0, 0, 0, 0, 8'd8, 15);
        add(1, 0, 8'd0, 1, 0, 0, 0, 0, 8'd8, 15);
        add(1, 0, 8'd0, 0, 0, 1, 0, 0, 8'd8, 15);
        add(1, 0, 8'd0, 0, 0, 0, 0, 0, 8'd8, 15);
        add(1, 0, 8'd0, 0, 0, 0, 0, 0, 8'd8, 15);
        add(1, 0, 8'd0, 0, 0, 0, 0, 0, 8'd8, 15);
        add(1, 0, 8'd0, 1, 1, 0, 0, 0, 8'd8, 16);
        // Illegal loads 1 and 0: two err pulses, and the ratio does not change.
        add(1, 1, 8'd1, 1, 0, 0, 0, 1, 8'd8, 16);
        add(1, 1, 8'd0, 1, 0, 0, 0, 1, 8'd8, 16);
        add(1, 0, 8'd0, 1, 0, 0, 0, 0, 8'd8, 16);
        add(1, 0, 8'd0, 0, 0, 1, 0, 0, 8'd8, 16);
        add(1, 0, 8'd0, 0, 0, 0, 0, 0, 8'd8, 16);
        add(1, 0, 8'd0, 0, 0, 0, 0, 0, 8'd8, 16);
        add(1, 0, 8'd0, 0, 0, 0, 0, 0, 8'd8, 16);
        add(1, 0, 8'd0, 1, 1, 0, 0, 0, 8'd8, 17);
        add(1, 0, 8'd0, 1, 0, 0, 0, 0, 8'd8, 17);
        // Drop ch_en at count=1. The full 4-high/4-low period finishes, then clk_out stays low.
        add(0, 0, 8'd0, 1, 0, 0, 0, 0, 8'd8, 17);
        add(0, 0, 8'd0, 1, 0, 0, 0, 0, 8'd8, 17);
        add(0, 0, 8'd0, 0, 0, 1, 0, 0, 8'd8, 17);
        add(0, 0, 8'd0, 0, 0, 0, 0, 0, 8'd8, 17);
        add(0, 0, 8'd0, 0, 0, 0, 0, 0, 8'd8, 17);
        add(0, 0, 8'd0, 0, 0, 0, 0, 0, 8'd8, 17);
        add(0, 0, 8'd0, 0, 0, 0, 0, 0, 8'd8, 17);
        add(0, 0, 8'd0, 0, 0, 0, 0, 0, 8'd8, 17);
        add(0, 0, 8'd0, 0, 0, 0, 0, 0, 8'd8, 17);
        // Re-enable: a full 4-cycle high phase.
        add(1, 0, 8'd0, 1, 1, 0, 0, 0, 8'd8, 18);
        add(1, 0, 8'd0, 1, 0, 0, 0, 0, 8'd8, 18);
        add(1, 0, 8'd0, 1, 0, 0, 0, 0, 8'd8, 18);
        add(1, 0, 8'd0, 1, 0, 0, 0, 0, 8'd8, 18);
        add(1, 0, 8'd0, 0, 0, 1, 0, 0, 8'd8, 18);

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_clk_out",      0, 64'(clk_out),      64'd0);
        chk("rst_strobes",      0, 64'({rise_strobe, fall_strobe, load_ack, load_err}), 64'd0);
        chk("rst_ratio_active", 0, 64'(ratio_active), 64'h0202);
        chk("rst_edge_count",   0, edge_count,        64'd0);
        rst_l = 1'b1;

        // ---------------- table run ----------------
        for (int r = 0; r < vq.size(); r++) begin
            ch_en      = {1'b0, vq[r].en};
            ratio_load = {1'b0, vq[r].ld};
            ratio_in   = {8'd0, vq[r].rin};
            step();
            $display("[TB] vec %0d en=%0b ld=%0b rin=%0d clk=%0b rise=%0b fall=%0b ack=%0b err=%0b ratio=%0d edges=%0d",
                     r + 1, vq[r].en, vq[r].ld, vq[r].rin, clk_out[0], rise_strobe[0],
                     fall_strobe[0], load_ack[0], load_err[0], ratio_active[7:0], edge_count[31:0]);
            chk("clk_out",      r + 1, 64'(clk_out[0]),        64'(vq[r].clk));
            chk("rise_strobe",  r + 1, 64'(rise_strobe[0]),    64'(vq[r].rise));
            chk("fall_strobe",  r + 1, 64'(fall_strobe[0]),    64'(vq[r].fall));
            chk("load_ack",     r + 1, 64'(load_ack[0]),       64'(vq[r].ack));
            chk("load_err",     r + 1, 64'(load_err[0]),       64'(vq[r].err));
            chk("ratio_active", r + 1, 64'(ratio_active[7:0]), 64'(vq[r].ratio));
            chk("edge_count",   r + 1, 64'(edge_count[31:0]),  64'(vq[r].edges));
        end
        chk("ch1_quiet_edges", 100, 64'(edge_count[63:32]), 64'd0);
        chk("ch1_quiet_clk",   100, 64'(clk_out[1]),        64'd0);

        // ---------------- reset mid-period, both channels ----------------
        // Channel 0 gets R=3 pending. Channel 1 gets R=6 while idle.
        ch_en      = 2'b01;
        ratio_load = 2'b11;
        ratio_in   = {8'd6, 8'd3};
        step();
        $display("[TB] seq 1 load ch0=3 ch1=6 clk=%b ack=%b", clk_out, load_ack);
        chk("seq1_clk", 101, 64'(clk_out), 64'b00);
        ratio_load = 2'b00;
        step();
        $display("[TB] seq 2 idle apply ch1 ack=%b ratio=%h", load_ack, ratio_active);
        chk("seq2_ack1",   102, 64'(load_ack),            64'b10);
        chk("seq2_ratio1", 102, 64'(ratio_active[15:8]),  64'd6);
        chk("seq2_clk",    102, 64'(clk_out),             64'b00);
        ch_en = 2'b11;
        step();
        $display("[TB] seq 3 enable ch1 clk=%b rise=%b", clk_out, rise_strobe);
        chk("seq3_clk",  103, 64'(clk_out),     64'b10);
        chk("seq3_rise", 103, 64'(rise_strobe), 64'b10);
        // A load on the wrap edge: the pending 3 is applied and 10 becomes pending.
        ratio_load = 2'b01;
        ratio_in   = {8'd0, 8'd10};
        step();
        $display("[TB] seq 4 wrap+load clk=%b rise=%b ack=%b ratio=%h", clk_out, rise_strobe, load_ack, ratio_active);
        chk("seq4_clk",    104, 64'(clk_out),      64'b11);
        chk("seq4_rise",   104, 64'(rise_strobe),  64'b01);
        chk("seq4_ack",    104, 64'(load_ack),     64'b01);
        chk("seq4_ratio",  104, 64'(ratio_active), 64'h0603);
        chk("seq4_edges0", 104, 64'(edge_count[31:0]),  64'd19);
        chk("seq4_edges1", 104, 64'(edge_count[63:32]), 64'd1);
        ratio_load = 2'b00;
        ratio_in   = 16'd0;
        ch_en      = 2'b00;
        #2;
        rst_l = 1'b0;
        #1;
        $display("[TB] seq 5 async reset clk=%b ratio=%h", clk_out, ratio_active);
        chk("seq5_clk_async", 105, 64'(clk_out),      64'b00);
        chk("seq5_ratio",     105, 64'(ratio_active), 64'h0202);
        chk("seq5_edges",     105, edge_count,        64'd0);
        chk("seq5_strobes",   105, 64'({rise_strobe, fall_strobe, load_ack}), 64'd0);
        step();
        rst_l = 1'b1;
        step();
        $display("[TB] seq 6 after release clk=%b ack=%b ratio=%h", clk_out, load_ack, ratio_active);
        chk("seq6_clk",   106, 64'(clk_out),      64'b00);
        chk("seq6_ack",   106, 64'(load_ack),     64'b00);
        chk("seq6_ratio", 106, 64'(ratio_active), 64'h0202);
        // The pending 10 on channel 0 was discarded, so both channels run at R=2.
        ch_en = 2'b11;
        step();
        $display("[TB] seq 7 enable both clk=%b rise=%b ack=%b", clk_out, rise_strobe, load_ack);
        chk("seq7_clk",   107, 64'(clk_out),     64'b11);
        chk("seq7_rise",  107, 64'(rise_strobe), 64'b11);
        chk("seq7_ack",   107, 64'(load_ack),    64'b00);
        chk("seq7_edges", 107, edge_count,       {32'd1, 32'd1});
        step();
        $display("[TB] seq 8 clk=%b fall=%b", clk_out, fall_strobe);
        chk("seq8_clk",  108, 64'(clk_out),     64'b00);
        chk("seq8_fall", 108, 64'(fall_strobe), 64'b11);
        step();
        $display("[TB] seq 9 clk=%b rise=%b ratio=%h", clk_out, rise_strobe, ratio_active);
        chk("seq9_clk",   109, 64'(clk_out),      64'b11);
        chk("seq9_rise",  109, 64'(rise_strobe),  64'b11);
        chk("seq9_ratio", 109, 64'(ratio_active), 64'h0202);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
